mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (IF) and load/store (D) paths.
//  Sequences each access through a fixed-latency memory port using a req/ready handshake.
//  Stalls the losing requester. Applies priority with a starvation guard.
//  Sits between Program_Counter/fetch logic, the load/store datapath and the memory macro.
// PARAMETERS
//  ADDR_W       64  address width
//  DATA_W       64  data width (fetch returns low 32 bits)
//  MEM_LAT      2   memory read latency in cycles, >=1
//  MAX_DSTREAK  4   max consecutive D grants while IF waits, >=1
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request; held stable until if_ready
//  if_addr    in   ADDR_W  fetch address
//  if_ready   out  1       1-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  32      fetched instruction
//  if_stall   out  1       if_req & ~if_ready
//  d_req      in   1       data request; held stable until d_ready
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_ready    out  1       1-cycle pulse: data access complete
//  d_rdata    out  DATA_W  load data (0 for stores)
//  d_stall    out  1       d_req & ~d_ready
//  mem_en     out  1       memory access active
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en rises
// BEHAVIOUR
//  Reset: state=IDLE. All outputs, latched addr/data, lat_cnt and streak are 0.
//  FSM states:
//   IDLE: no request -> stay. Any request -> pick a winner, latch owner/addr/we/wdata, go BUSY.
//   BUSY: mem_* driven from latches, lat_cnt++. At lat_cnt==MEM_LAT-1: capture mem_rdata, go DONE.
//   DONE: pulse owner's ready with captured data; mem_en=0; go IDLE.
//  Latency: req sampled in cycle 0 -> ready in cycle MEM_LAT+1. Back-to-back grants need >=1 IDLE cycle.
//  Arbitration at IDLE:
//   - D wins by default.
//   - IF wins if only IF requests, or if streak==MAX_DSTREAK with both requesting.
//   - streak: +1 on a D grant while if_req=1; cleared on an IF grant or a D grant with if_req=0.
//   - Saturates at MAX_DSTREAK.
//  Stores: mem_we=1 for all BUSY cycles. d_rdata=0 on d_ready.
//  Output timing: ready/rdata registered, asserted only in DONE. rdata returns to 0 otherwise.
//  A requester that keeps req high after ready is treated as a new request in the next IDLE.
//  A req dropped before ready is a protocol violation; the latched access still completes.
//  Asserting reset low mid-BUSY aborts the access: no ready pulse, mem_en/mem_we drop asynchronously.
//  Address is not range-checked; it passes through unchanged.
// STRUCTURE
//  Shared package arb_pkg:
//   - state encodings IDLE/BUSY/DONE
//   - owner constants OWN_IF=0, OWN_D=1
//   - localparam LAT_W=$clog2(MEM_LAT+1)
//  Sub-module mem_lat_counter: load/enable counter with terminal-count flag.
//  The FSM, arbitration and latches stay in this module.
// TESTING (MEM_LAT=2, MAX_DSTREAK=2 unless noted)
//  1 Single fetch: if_req=1, if_addr=0x40, mem_rdata=0x00000013
//    -> mem_en cycles 1-2, if_ready=1 with if_rdata=0x13 in cycle 3.
//  2 Both request in cycle 0
//    -> D granted first (d_ready cycle 3), IF granted in cycle 4 IDLE, if_ready in cycle 7.
//  3 Starvation guard: d_req held high, if_req held high
//    -> grants D, D, IF, D, D, IF. if_stall stays high until each IF pulse.
//  4 Store: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF
//    -> mem_we=1 with that addr/data for 2 cycles, d_ready pulse, d_rdata=0.
//  5 Reset low in first BUSY cycle
//    -> mem_en=0 immediately, no ready pulse. After release, the held request is re-arbitrated from IDLE.
//  6 MEM_LAT=1, fetches to 0x0 then 0x4 back-to-back
//    -> if_ready in cycles 2 and 5, correct data each time.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the IF/D memory port arbiter: FSM states, owner ids,
// latency-counter sizing.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   localparam int DEF_MEM_LAT = 2;
   localparam int LAT_W       = $clog2(DEF_MEM_LAT + 1);

   // Counter width for an arbitrary latency; must hold the value MEM_LAT.
   function automatic int lat_w(input int mem_lat);
      return $clog2(mem_lat + 1);
   endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Load/enable up-counter with a terminal-count flag, used to time the
// fixed-latency memory access.
module mem_lat_counter #(
   parameter int W  = 2,
   parameter int TC = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)    cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == W'(TC));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store,
// D-priority with a bounded D streak so a waiting fetch cannot starve.
module mem_port_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int MEM_LAT     = 2,
   parameter int MAX_DSTREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [31:0]       if_rdata,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

   arb_state_e        state_q;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [SW-1:0]     streak_q, streak_d;
   logic              mem_en_q, mem_we_q;
   logic              if_ready_q, d_ready_q;
   logic [31:0]       if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic any_req, d_wins, grant, lat_tc;

   assign any_req = if_req | d_req;
   assign d_wins  = d_req & ~(if_req & (streak_q == STREAK_MAX));
   assign grant   = (state_q == IDLE) & any_req;

   // Streak counts D grants taken while IF was waiting; only consumed on grant.
   always_comb begin
      streak_d = '0;
      if (d_wins && if_req)
         streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
   end

   mem_lat_counter #(
      .W  (lat_w(MEM_LAT)),
      .TC (MEM_LAT - 1)
   ) u_lat (
      .clk    (clk),
      .reset  (reset),
      .load_i (grant),
      .en_i   (state_q == BUSY),
      .tc_o   (lat_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         streak_q   <= '0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_ready_q <= 1'b0;
         if_rdata_q <= '0;
         d_ready_q  <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q  <= BUSY;
                  owner_q  <= d_wins ? OWN_D : OWN_IF;
                  addr_q   <= d_wins ? d_addr : if_addr;
                  we_q     <= d_wins & d_we;
                  wdata_q  <= d_wins ? d_wdata : '0;
                  streak_q <= streak_d;
                  mem_en_q <= 1'b1;
                  mem_we_q <= d_wins & d_we;
               end
            end
            BUSY: begin
               if (lat_tc) begin
                  state_q  <= DONE;
                  mem_en_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  if (owner_q == OWN_IF) begin
                     if_ready_q <= 1'b1;
                     if_rdata_q <= mem_rdata[31:0];
                  end else begin
                     d_ready_q <= 1'b1;
                     d_rdata_q <= we_q ? '0 : mem_rdata;
                  end
               end
            end
            DONE: begin
               state_q    <= IDLE;
               if_ready_q <= 1'b0;
               if_rdata_q <= '0;
               d_ready_q  <= 1'b0;
               d_rdata_q  <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_ready  = if_ready_q;
   assign if_rdata  = if_rdata_q;
   assign d_ready   = d_ready_q;
   assign d_rdata   = d_rdata_q;
   assign if_stall  = if_req & ~if_ready_q;
   assign d_stall   = d_req & ~d_ready_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_en_q ? addr_q : '0;
   assign mem_wdata = mem_we_q ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random IF/D traffic against a transaction-timing model of the arbiter, plus
// a directed back-to-back fetch on a MEM_LAT=1 instance and a mid-access reset.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int MAXS = 2;
   localparam logic [63:0] JUNK = 64'hDEAD_0BAD_DEAD_0BAD;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // instance 0: MEM_LAT=2, MAX_DSTREAK=2
   logic        if_req = 0, d_req = 0, d_we = 0;
   logic [63:0] if_addr = 0, d_addr = 0, d_wdata = 0;
   logic        if_ready, if_stall, d_ready, d_stall, mem_en, mem_we;
   logic [31:0] if_rdata;
   logic [63:0] d_rdata, mem_addr, mem_wdata, mem_rdata;

   // instance 1: MEM_LAT=1, fetch only
   logic        if1_req = 0, d1_req = 0, d1_we = 0;
   logic [63:0] if1_addr = 0, d1_addr = 0, d1_wdata = 0;
   logic        if1_ready, if1_stall, d1_ready, d1_stall, mem1_en, mem1_we;
   logic [31:0] if1_rdata;
   logic [63:0] d1_rdata, mem1_addr, mem1_wdata, mem1_rdata;

   int checks = 0, fails = 0, t = 0;
   int en_cnt0 = 0;

   function automatic logic [63:0] rd(input logic [63:0] a);
      return {a[63:32] + 32'h0000_0013, a[31:0] ^ 32'h5A5A_1234};
   endfunction

   // memory answers only in the cycle the arbiter is expected to capture
   always @(posedge clk or negedge reset)
      if (!reset) en_cnt0 <= 0;
      else        en_cnt0 <= mem_en ? en_cnt0 + 1 : 0;
   assign mem_rdata  = (mem_en && en_cnt0 == LAT - 1) ? rd(mem_addr) : JUNK;
   assign mem1_rdata = mem1_en ? rd(mem1_addr) : JUNK;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .MAX_DSTREAK(MAXS)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .if_stall(if_stall), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata));

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .MAX_DSTREAK(MAXS)) dut1 (
      .clk(clk), .reset(reset),
      .if_req(if1_req), .if_addr(if1_addr), .if_ready(if1_ready), .if_rdata(if1_rdata),
      .if_stall(if1_stall), .d_req(d1_req), .d_we(d1_we), .d_addr(d1_addr),
      .d_wdata(d1_wdata), .d_ready(d1_ready), .d_rdata(d1_rdata), .d_stall(d1_stall),
      .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
      .mem_rdata(mem1_rdata));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask

   // model: one access in flight, granted at m_grant, ready at m_grant+LAT+1
   bit          m_busy = 0, m_own_d = 0, m_we = 0;
   int          m_grant = 0, m_done = 0, streak = 0;
   logic [63:0] m_addr = 0, m_wdata = 0, m_data = 0;
   bit          if_pend = 0, d_pend = 0, if_got = 0, d_got = 0;
   int          if_grants = 0, d_grants = 0;

   task automatic step();
      bit ifr, dr, en_e, dw;
      logic [63:0] r, ifd, dd;
      ifr = 0; dr = 0; ifd = 0; dd = 0;
      en_e = m_busy && (t > m_grant) && (t <= m_grant + LAT);
      if (m_busy && t == m_done) begin
         if (m_own_d) begin dr = 1; dd = m_data; end
         else begin ifr = 1; ifd = m_data; end
      end
      chk("if_ready", if_ready, ifr);
      chk("if_rdata", if_rdata, ifd);
      chk("d_ready", d_ready, dr);
      chk("d_rdata", d_rdata, dd);
      chk("mem_en", mem_en, en_e);
      chk("mem_we", mem_we, en_e && m_we);
      chk("mem_addr", mem_addr, en_e ? m_addr : 64'd0);
      chk("mem_wdata", mem_wdata, (en_e && m_we) ? m_wdata : 64'd0);
      chk("if_stall", if_stall, if_req && !ifr);
      chk("d_stall", d_stall, d_req && !dr);
      if (if_ready) if_got = 1;
      if (d_ready)  d_got = 1;
      if (m_busy) begin
         if (t == m_done) m_busy = 0;
      end else if (if_req || d_req) begin
         dw = d_req && !(if_req && streak == MAXS);
         if (dw) streak = if_req ? ((streak < MAXS) ? streak + 1 : streak) : 0;
         else    streak = 0;
         if (dw) d_grants++; else if_grants++;
         m_busy  = 1;
         m_grant = t;
         m_done  = t + LAT + 1;
         m_own_d = dw;
         m_addr  = dw ? d_addr : if_addr;
         m_we    = dw && d_we;
         m_wdata = d_wdata;
         r       = rd(m_addr);
         m_data  = m_we ? 64'd0 : (dw ? r : {32'd0, r[31:0]});
      end
   endtask

   task automatic drive();
      if (!if_pend || if_got) begin
         if_got = 0;
         if ($urandom_range(3) != 0) begin
            if_req = 1; if_pend = 1;
            if_addr = {$urandom, $urandom & 32'hFFFF_FFFC};
         end else begin
            if_req = 0; if_pend = 0;
         end
      end
      if (!d_pend || d_got) begin
         d_got = 0;
         if ($urandom_range(3) != 0) begin
            d_req = 1; d_pend = 1;
            d_we = $urandom_range(1);
            d_addr = {$urandom, $urandom};
            d_wdata = {$urandom, $urandom};
         end else begin
            d_req = 0; d_pend = 0;
         end
      end
   endtask

   initial begin
      logic [63:0] r0, r4, exp1;
      bit inj_done;
      inj_done = 0;
      r0 = rd(64'h0);
      r4 = rd(64'h4);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst1_mem_en", mem1_en, 0);
      reset = 1;

      // MEM_LAT=1: fetch 0x0 then 0x4 back-to-back
      @(posedge clk); #1;
      if1_req = 1; if1_addr = 64'h0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         exp1 = (c == 2) ? {32'd0, r0[31:0]} : (c == 5) ? {32'd0, r4[31:0]} : 64'd0;
         chk("lat1_if_ready", if1_ready, (c == 2 || c == 5));
         chk("lat1_if_rdata", if1_rdata, exp1);
         chk("lat1_mem_en", mem1_en, (c == 1 || c == 4));
         @(posedge clk); #1;
         if (c == 2) if1_addr = 64'h4;
         if (c == 5) if1_req = 0;
      end

      // random traffic on the MEM_LAT=2 instance
      t = 0;
      for (int n = 0; n < 800; n++) begin
         @(posedge clk); t++; #1;
         drive();
         if (!inj_done && t > 40 && m_busy && t == m_grant + 1) begin
            inj_done = 1;
            reset = 0;
            #1;
            chk("rstmid_mem_en", mem_en, 0);
            chk("rstmid_mem_we", mem_we, 0);
            chk("rstmid_if_ready", if_ready, 0);
            chk("rstmid_d_ready", d_ready, 0);
            m_busy = 0;
            streak = 0;
            @(posedge clk); t++; #1;
            reset = 1;
         end
         @(negedge clk);
         step();
      end
      chk("reset_injected", inj_done, 1);
      chk("if_granted", if_grants > 20, 1);
      chk("d_granted", d_grants > 20, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
